// File: rtl/bpu_pkg.sv
// rtl/bpu_pkg.sv - shared types for the branch prediction feedback path
package bpu_pkg;
  localparam int BPU_ADDR_WIDTH = 8;

  typedef enum logic {RUN, FLUSH} resolver_state_t;

  typedef struct packed {
    logic [BPU_ADDR_WIDTH-1:0] pc;
    logic                      taken;
    logic [BPU_ADDR_WIDTH-1:0] target;
  } pred_entry_t;

  // A target only matters when both sides agree the branch was taken.
  function automatic logic is_mispredict(input pred_entry_t e, input logic taken,
                                         input logic [BPU_ADDR_WIDTH-1:0] target);
    return (e.taken != taken) | (e.taken & taken & (e.target != target));
  endfunction
endpackage

// File: rtl/pred_fifo.sv
// rtl/pred_fifo.sv - in-flight prediction FIFO with push, pop, clear and count
module pred_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 clear_i,
  input  pred_entry_t          din_i,
  output pred_entry_t          head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [CNT_WIDTH-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);

  pred_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_push;
  logic                 w_pop;

  assign full_o  = (r_count == CNT_WIDTH'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= din_i;
  end

  // Clear outranks any same-cycle push or pop.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - matches in-flight predictions to execute outcomes,
// trains the predictor and flushes/redirects fetch on a mispredict
module branch_resolver
  import bpu_pkg::*;
#(
  parameter int ADDR_WIDTH = BPU_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pred_valid_i,
  input  logic                  pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] pred_pc_i,
  input  logic [ADDR_WIDTH-1:0] pred_target_i,
  output logic                  pred_ready_o,
  input  logic                  res_valid_i,
  input  logic                  res_taken_i,
  input  logic [ADDR_WIDTH-1:0] res_target_i,
  output logic                  upd_valid_o,
  output logic [ADDR_WIDTH-1:0] upd_pc_o,
  output logic                  conditional_jump_o,
  output logic                  shouldnt_jump_o,
  output logic                  flush_o,
  output logic [ADDR_WIDTH-1:0] redirect_pc_o,
  output logic [CNT_WIDTH-1:0]  occupancy_o,
  output logic                  err_underflow_o
);
  resolver_state_t       r_state;
  logic                  r_upd_valid, r_cond_jump, r_shouldnt, r_flush, r_err;
  logic [ADDR_WIDTH-1:0] r_upd_pc, r_redirect;
  pred_entry_t           w_din, w_head;
  logic                  w_full, w_empty, w_ready, w_pop, w_mis, w_push;
  logic [ADDR_WIDTH-1:0] w_fallthrough;

  assign w_din         = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};
  assign w_ready       = (r_state == RUN) & ~w_full;
  assign w_pop         = res_valid_i & (r_state == RUN) & ~w_empty;
  assign w_mis         = w_pop & is_mispredict(w_head, res_taken_i, res_target_i);
  assign w_push        = pred_valid_i & w_ready & ~w_mis;
  assign w_fallthrough = w_head.pc + 1'b1;

  pred_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .clear_i (w_mis),
    .din_i   (w_din),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (occupancy_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= RUN;
      r_upd_valid <= 1'b0;
      r_upd_pc    <= '0;
      r_cond_jump <= 1'b0;
      r_shouldnt  <= 1'b0;
      r_flush     <= 1'b0;
      r_redirect  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_upd_valid <= w_pop;
      r_cond_jump <= w_pop & res_taken_i;
      r_shouldnt  <= w_pop & w_head.taken & ~res_taken_i;
      r_flush     <= w_mis;
      if (w_pop) r_upd_pc <= w_head.pc;
      if (w_mis) r_redirect <= res_taken_i ? res_target_i : w_fallthrough;
      // A resolve with nothing to match (empty or mid-flush) is a protocol error.
      if (res_valid_i && !w_pop) r_err <= 1'b1;
      r_state <= w_mis ? FLUSH : RUN;
    end
  end

  assign pred_ready_o       = w_ready;
  assign upd_valid_o        = r_upd_valid;
  assign upd_pc_o           = r_upd_pc;
  assign conditional_jump_o = r_cond_jump;
  assign shouldnt_jump_o    = r_shouldnt;
  assign flush_o            = r_flush;
  assign redirect_pc_o      = r_redirect;
  assign err_underflow_o    = r_err;
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed and random checks of branch_resolver against a queue model
module tb_branch_resolver;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       pred_valid_i = 1'b0, pred_taken_i = 1'b0;
  logic [7:0] pred_pc_i = '0, pred_target_i = '0;
  logic       res_valid_i = 1'b0, res_taken_i = 1'b0;
  logic [7:0] res_target_i = '0;
  logic       pred_ready_o, upd_valid_o, conditional_jump_o, shouldnt_jump_o, flush_o, err_underflow_o;
  logic [7:0] upd_pc_o, redirect_pc_o;
  logic [2:0] occupancy_o;

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk_i(clk), .rst_i(rst_i),
    .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i),
    .pred_pc_i(pred_pc_i), .pred_target_i(pred_target_i), .pred_ready_o(pred_ready_o),
    .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
    .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
    .conditional_jump_o(conditional_jump_o), .shouldnt_jump_o(shouldnt_jump_o),
    .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
    .occupancy_o(occupancy_o), .err_underflow_o(err_underflow_o)
  );

  typedef struct { logic [7:0] pc; logic taken; logic [7:0] tgt; } ent_t;
  ent_t       q[$];
  bit         m_in_flush, m_err, m_upd, m_cj, m_sj, m_fl;
  logic [7:0] m_upd_pc, m_redir;
  int         n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model one clock edge with the currently driven inputs, then compare.
  task automatic cycle();
    bit   exp_ready, popped, push_ok, mis;
    ent_t h, e;
    exp_ready = !m_in_flush && (q.size() < DEPTH);
    if (!rst_i) chk("pred_ready", pred_ready_o, exp_ready);
    if (rst_i) begin
      q.delete();
      {m_in_flush, m_err, m_upd, m_cj, m_sj, m_fl} = '0;
      m_upd_pc = 8'h00; m_redir = 8'h00;
    end else begin
      {m_upd, m_cj, m_sj, m_fl} = '0;
      popped  = res_valid_i && !m_in_flush && (q.size() > 0);
      push_ok = pred_valid_i && exp_ready;
      if (res_valid_i && !popped) m_err = 1'b1;
      m_in_flush = 1'b0;
      if (popped) begin
        h = q.pop_front();
        mis = (h.taken != res_taken_i) || (h.taken && res_taken_i && h.tgt != res_target_i);
        m_upd = 1'b1; m_upd_pc = h.pc;
        m_cj = res_taken_i; m_sj = h.taken && !res_taken_i;
        if (mis) begin
          m_fl = 1'b1;
          m_redir = res_taken_i ? res_target_i : 8'((int'(h.pc) + 1) % 256);
          q.delete();
          push_ok = 1'b0;
          m_in_flush = 1'b1;
        end
      end
      if (push_ok) begin
        e.pc = pred_pc_i; e.taken = pred_taken_i; e.tgt = pred_target_i;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("upd_valid", upd_valid_o, m_upd);
    chk("upd_pc", upd_pc_o, m_upd_pc);
    chk("cond_jump", conditional_jump_o, m_cj);
    chk("shouldnt_jump", shouldnt_jump_o, m_sj);
    chk("flush", flush_o, m_fl);
    chk("redirect_pc", redirect_pc_o, m_redir);
    chk("occupancy", occupancy_o, q.size());
    chk("err_underflow", err_underflow_o, m_err);
  endtask

  task automatic drive(input bit pv, input bit pt, input logic [7:0] pc, input logic [7:0] pg,
                       input bit rv, input bit rt, input logic [7:0] rg);
    pred_valid_i = pv; pred_taken_i = pt; pred_pc_i = pc; pred_target_i = pg;
    res_valid_i = rv; res_taken_i = rt; res_target_i = rg;
  endtask

  initial begin
    // Reset then idle
    rst_i = 1'b1; drive(0,0,0,0,0,0,0); cycle();
    rst_i = 1'b0; cycle();
    chk("idle_ready", pred_ready_o, 1'b1);

    // Correct prediction
    drive(1,1,8'h10,8'h40,0,0,0); cycle();
    chk("occ_one", occupancy_o, 3'd1);
    drive(0,0,0,0,1,1,8'h40); cycle();
    chk("correct_upd_pc", upd_pc_o, 8'h10);
    chk("correct_noflush", flush_o, 1'b0);

    // Direction mispredict with pc wrap
    drive(1,1,8'hFF,8'h20,0,0,0); cycle();
    drive(1,0,8'h21,8'h00,0,0,0); cycle();
    drive(1,0,8'h22,8'h00,0,0,0); cycle();
    drive(0,0,0,0,1,0,8'h00); cycle();
    chk("wrap_redirect", redirect_pc_o, 8'h00);
    chk("wrap_flush", flush_o, 1'b1);
    drive(0,0,0,0,0,0,0);
    chk("flush_state_ready", pred_ready_o, 1'b0);
    cycle();
    chk("after_flush_ready", pred_ready_o, 1'b1);

    // Target mispredict
    drive(1,1,8'h30,8'h50,0,0,0); cycle();
    drive(0,0,0,0,1,1,8'h60); cycle();
    chk("tgt_redirect", redirect_pc_o, 8'h60);
    drive(0,0,0,0,0,0,0); cycle();

    // Full, 5th push refused, pop+push at 3, push during mispredict
    for (int i = 0; i < 5; i++) begin
      drive(1,1,8'(8'h50 + i),8'h70,0,0,0); cycle();
    end
    chk("full_occ", occupancy_o, 3'd4);
    chk("full_ready", pred_ready_o, 1'b0);
    drive(0,0,0,0,1,1,8'h70); cycle();
    drive(1,1,8'h60,8'h70,1,1,8'h70); cycle();
    chk("pop_push_occ", occupancy_o, 3'd3);
    drive(1,1,8'h61,8'h70,1,0,8'h00); cycle();
    chk("mis_push_dropped", occupancy_o, 3'd0);

    // Underflow: during FLUSH, then while empty; sticky until reset
    drive(0,0,0,0,1,0,0); cycle();
    cycle();
    drive(0,0,0,0,0,0,0); cycle();
    chk("err_sticky", err_underflow_o, 1'b1);
    rst_i = 1'b1; cycle();
    rst_i = 1'b0;
    chk("err_cleared", err_underflow_o, 1'b0);

    // Random traffic; targets drawn from a small set so both outcomes occur
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0,1), $urandom_range(0,1), 8'($urandom), 8'($urandom_range(8'hFE,8'hFF)),
            ($urandom_range(0,2) == 0), $urandom_range(0,3) != 0, 8'($urandom_range(8'hFE,8'hFF)));
      cycle();
    end
    rst_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
